dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Sits directly downstream of the 5-stage core's MEM-stage data port; consumes its mem_read/mem_write/mem_addr/mem_wdata and returns read data.
- Converts the core's single-cycle access model into a valid/ready request plus response handshake to a variable-latency external data memory.
- Holds a posted write buffer so stores do not stall the pipeline.
- Asserts cpu_stall while a load is outstanding or the buffer is full.

Parameters:
- ADDR_WIDTH, 32, byte address width (matches core word width).
- DATA_WIDTH, 32, data word width.
- WBUF_DEPTH, 4, posted-write FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- cpu_read  in  1  load request from MEM stage, held stable while cpu_stall=1.
- cpu_write  in  1  store request from MEM stage.
- cpu_addr  in  ADDR_WIDTH  access address.
- cpu_wdata  in  DATA_WIDTH  store data.
- cpu_rdata  out  DATA_WIDTH  load data, registered; valid in the cycle cpu_stall drops for a load.
- cpu_stall  out  1  freeze pipeline, combinational.
- m_req_valid  out  1  memory request valid.
- m_req_ready  in  1  memory accepts request.
- m_req_we  out  1  1=write, 0=read.
- m_req_addr  out  ADDR_WIDTH  request address.
- m_req_wdata  out  DATA_WIDTH  request write data.
- m_resp_valid  in  1  one-cycle pulse; read data valid, or write ack.
- m_resp_rdata  in  DATA_WIDTH  read response data.
- wbuf_empty  out  1  status: write buffer empty (for fence/halt logic).

Behaviour:
- Reset (rst=0, async): FSM=IDLE, FIFO pointers/count=0, rd_done=0, cpu_rdata=0, m_req_valid=0, m_req_we=0, m_req_addr=0, m_req_wdata=0, wbuf_empty=1.
- Reset mid-transaction drops the transaction; m_resp_valid arriving in IDLE after reset is ignored.
- Single outstanding memory transaction at a time.
- m_req_* are registered and held stable while m_req_valid=1 && m_req_ready=0.
- The request completes on the clock edge where m_req_valid && m_req_ready. The FSM then waits for m_resp_valid.
- FSM states: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
- IDLE transitions:
  - to RD_REQ if a load is pending, not complete, and the read is permitted (see ordering);
  - else to WR_REQ if FIFO non-empty;
  - a load pending has priority over draining.
- WR_REQ -> WR_WAIT on accept. WR_WAIT -> IDLE on m_resp_valid; FIFO entry popped at that edge.
- RD_REQ -> RD_WAIT on accept. RD_WAIT -> IDLE on m_resp_valid; cpu_rdata<=m_resp_rdata and rd_done<=1 at that edge.
- rd_done clears on the edge following the cycle it was 1, when the pipeline advances.
- cpu_stall = (cpu_read && !rd_done) || (cpu_write && wbuf_full && !pop_this_cycle).
- Stores:
  - cpu_write && !cpu_stall pushes {addr,wdata} into the FIFO at the edge.
  - A simultaneous push and pop when full is allowed, and count is unchanged.
- Ordering: without forwarding, a load waits in IDLE until the FIFO drains to empty. Write responses are always in FIFO order.
- cpu_read && cpu_write in the same cycle is illegal. The write is ignored and the read is serviced. The bench flags this.
- Pointer wrap: modulo WBUF_DEPTH. count width is clog2(WBUF_DEPTH)+1.
- Minimum load latency with zero-wait memory: 3 stall cycles (RD_REQ, RD_WAIT, rd_done register).

Optional Feature:
- DMEM_WBUF_FWD_EN defined:
  - On cpu_read in IDLE, all valid FIFO entries are compared against cpu_addr.
  - On a hit, the newest matching entry's data goes to cpu_rdata at the next edge, rd_done<=1, and no memory read is issued (1 stall cycle).
  - On a miss, the load may bypass buffered writes and go to RD_REQ immediately.
- Undefined: no comparators; loads always wait for the FIFO to empty, then read memory.

Test Plan:
- Reset then idle: rst=0 for 2 cycles -> cpu_stall=0, m_req_valid=0, wbuf_empty=1, cpu_rdata=0.
- Load, zero-wait memory: cpu_read=1, addr=0x40, memory returns 0xDEADBEEF one cycle after accept -> stall held exactly 3 cycles; cpu_rdata=0xDEADBEEF when stall drops.
- Store burst with m_req_ready=0: 5 stores, WBUF_DEPTH=4 -> first 4 no stall; 5th stalls until ready=1 and the first write's ack; 5 writes issued in order with correct addr/data.
- Store then load same address, forwarding on: write 0x10<=0x1234; read 0x10 next cycle -> 1 stall cycle, cpu_rdata=0x1234, no m_req_we=0 request issued.
- Same stimulus, forwarding off: the read is issued only after the write ack; memory returns 0x1234; wbuf_empty=1 before the read request.
- Reset asserted in RD_WAIT: then a late m_resp_valid arrives -> FSM stays IDLE, cpu_rdata=0, no stall.

Source files
------------

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the MEM-stage single-cycle port into a valid/ready
// request + response handshake, with a posted write FIFO. Optional store-to-load
// forwarding from the FIFO is enabled by defining DMEM_WBUF_FWD_EN.
module dmem_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output logic                  m_req_we,
    output logic [ADDR_WIDTH-1:0] m_req_addr,
    output logic [DATA_WIDTH-1:0] m_req_wdata,
    input  logic                  m_resp_valid,
    input  logic [DATA_WIDTH-1:0] m_resp_rdata,
    output logic                  wbuf_empty
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0] wbuf_addr [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wbuf_data [WBUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  rd_done_reg;

    logic                  wbuf_full;
    logic                  load_pending;
    logic                  push;
    logic                  pop;
    logic                  rd_capture;
    logic                  load_rd;
    logic                  load_wr;
    logic                  fwd_take;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  rd_permit;

    assign wbuf_full    = (count_reg == CNT_W'(WBUF_DEPTH));
    assign wbuf_empty   = (count_reg == '0);
    assign load_pending = cpu_read && !rd_done_reg;
    assign pop          = (state_reg == WR_WAIT) && m_resp_valid;
    assign rd_capture   = (state_reg == RD_WAIT) && m_resp_valid;

    // A pop in the same cycle frees a slot, so a store to a full buffer need not wait.
    assign cpu_stall = load_pending || (cpu_write && wbuf_full && !pop);
    // A read+write in one cycle is illegal; the store half is dropped.
    assign push      = cpu_write && !cpu_read && !cpu_stall;

`ifdef DMEM_WBUF_FWD_EN
    logic [WBUF_DEPTH-1:0] age_hit;
    logic [DATA_WIDTH-1:0] age_data [WBUF_DEPTH];

    // Age 0 is the oldest entry (FIFO head); higher ages are newer stores.
    generate
        for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_cmp
            logic [PTR_W-1:0] slot;
            assign slot         = rd_ptr_reg + PTR_W'(gi);
            assign age_hit[gi]  = (CNT_W'(gi) < count_reg) && (wbuf_addr[slot] == cpu_addr);
            assign age_data[gi] = wbuf_data[slot];
        end
    endgenerate

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (age_hit[i]) begin
                fwd_hit  = 1'b1;
                fwd_data = age_data[i];
            end
        end
    end

    // A miss cannot alias any buffered store, so the load may overtake them.
    assign rd_permit = !fwd_hit;
`else
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
    assign rd_permit = wbuf_empty;
`endif

    always_comb begin
        state_next = state_reg;
        load_rd    = 1'b0;
        load_wr    = 1'b0;
        fwd_take   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_pending && fwd_hit) begin
                    fwd_take = 1'b1;
                end else if (load_pending && rd_permit) begin
                    state_next = RD_REQ;
                    load_rd    = 1'b1;
                end else if (!wbuf_empty) begin
                    state_next = WR_REQ;
                    load_wr    = 1'b1;
                end
            end
            WR_REQ:  if (m_req_ready)  state_next = WR_WAIT;
            WR_WAIT: if (m_resp_valid) state_next = IDLE;
            RD_REQ:  if (m_req_ready)  state_next = RD_WAIT;
            RD_WAIT: if (m_resp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_req_valid <= 1'b0;
            m_req_we    <= 1'b0;
            m_req_addr  <= '0;
            m_req_wdata <= '0;
        end else if (load_rd) begin
            m_req_valid <= 1'b1;
            m_req_we    <= 1'b0;
            m_req_addr  <= cpu_addr;
            m_req_wdata <= '0;
        end else if (load_wr) begin
            m_req_valid <= 1'b1;
            m_req_we    <= 1'b1;
            m_req_addr  <= wbuf_addr[rd_ptr_reg];
            m_req_wdata <= wbuf_data[rd_ptr_reg];
        end else if (m_req_valid && m_req_ready) begin
            m_req_valid <= 1'b0;
        end
    end

    // rd_done is a one-cycle flag: it lets the stalled load retire, then clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata   <= '0;
            rd_done_reg <= 1'b0;
        end else if (rd_capture) begin
            cpu_rdata   <= m_resp_rdata;
            rd_done_reg <= 1'b1;
        end else if (fwd_take) begin
            cpu_rdata   <= fwd_data;
            rd_done_reg <= 1'b1;
        end else begin
            rd_done_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            wbuf_addr[wr_ptr_reg] <= cpu_addr;
            wbuf_data[wr_ptr_reg] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: a small memory responder answers one cycle
// after each accept, logs every request, and each task checks one scenario.
module tb_dmem_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LOG_MAX = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_read;
    logic          cpu_write;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          m_req_valid;
    logic          m_req_ready;
    logic          m_req_we;
    logic [AW-1:0] m_req_addr;
    logic [DW-1:0] m_req_wdata;
    logic          m_resp_valid;
    logic [DW-1:0] m_resp_rdata;
    logic          wbuf_empty;

    int checks = 0;
    int errors = 0;

    bit            auto_resp = 1'b1;
    int            late_req  = 0;
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    logic          log_we    [LOG_MAX];
    logic [AW-1:0] log_addr  [LOG_MAX];
    logic [DW-1:0] log_wdata [LOG_MAX];
    logic          log_wbe   [LOG_MAX];
    int            log_n = 0;

    always #5 clk = ~clk;

    dmem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WBUF_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req_we     (m_req_we),
        .m_req_addr   (m_req_addr),
        .m_req_wdata  (m_req_wdata),
        .m_resp_valid (m_resp_valid),
        .m_resp_rdata (m_resp_rdata),
        .wbuf_empty   (wbuf_empty)
    );

    // Memory responder: answers in the cycle after the accepting edge.
    initial begin : responder
        int late_seen;
        logic [AW-1:0] a;
        late_seen    = 0;
        m_resp_valid = 1'b0;
        m_resp_rdata = '0;
        forever begin
            @(negedge clk);
            if (late_req != late_seen) begin
                late_seen = late_req;
                @(posedge clk); #1;
                m_resp_valid = 1'b1;
                m_resp_rdata = 32'hBAD0_BAD0;
                @(posedge clk); #1;
                m_resp_valid = 1'b0;
            end else if (auto_resp && rst && m_req_valid && m_req_ready) begin
                a = m_req_addr;
                if (log_n < LOG_MAX) begin
                    log_we[log_n]    = m_req_we;
                    log_addr[log_n]  = a;
                    log_wdata[log_n] = m_req_wdata;
                    log_wbe[log_n]   = wbuf_empty;
                    log_n++;
                end
                if (m_req_we) mem_model[a] = m_req_wdata;
                @(posedge clk); #1;
                m_resp_valid = 1'b1;
                m_resp_rdata = m_req_we ? '0 : (mem_model.exists(a) ? mem_model[a] : '0);
                @(posedge clk); #1;
                m_resp_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_stall_drop(output int n, output bit to);
        n  = 0;
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                to = 1'b0;
                break;
            end
            n++;
        end
    endtask

    task automatic wait_drain(output bit to);
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (wbuf_empty && !m_req_valid && !m_resp_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0)   begin errors++; $display("FAIL reset_stall actual=%b required=0", cpu_stall); end
        checks++; if (m_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid actual=%b required=0", m_req_valid); end
        checks++; if (wbuf_empty !== 1'b1)  begin errors++; $display("FAIL reset_wbuf_empty actual=%b required=1", wbuf_empty); end
        checks++; if (cpu_rdata !== '0)     begin errors++; $display("FAIL reset_rdata actual=%h required=0", cpu_rdata); end
        step(); rst = 1'b1;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0 || m_req_valid !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset stall=%b req_valid=%b required 0/0", cpu_stall, m_req_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_load();
        int n; bit to; int base;
        base = log_n;
        step(); cpu_read = 1'b1; cpu_addr = 32'h40;
        wait_stall_drop(n, to);
        checks++; if (to || n != 3) begin errors++; $display("FAIL load_stall_cycles actual=%0d required=3", n); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata actual=%h required=deadbeef", cpu_rdata); end
        step(); cpu_read = 1'b0;
        checks++; if (log_n - base != 1 || log_we[base] !== 1'b0 || log_addr[base] !== 32'h40) begin
            errors++; $display("FAIL load_request count=%0d we=%b addr=%h required 1/0/00000040", log_n - base, log_we[base], log_addr[base]);
        end
        $display("test_load done: stall=%0d rdata=%h", n, cpu_rdata);
    endtask

    task automatic test_store_burst();
        int n; bit to; int base; bit held;
        base = log_n;
        step(); m_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpu_write = 1'b1;
            cpu_addr  = 32'h100 + 32'(4 * i);
            cpu_wdata = 32'hA0 + 32'(i);
            @(negedge clk);
            checks++;
            if (cpu_stall !== (i == 4)) begin
                errors++; $display("FAIL store_stall_%0d actual=%b required=%b", i, cpu_stall, i == 4);
            end
            if (i < 4) step();
        end
        held = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (cpu_stall !== 1'b1) held = 1'b0;
        end
        checks++; if (!held) begin errors++; $display("FAIL store_full_hold actual=released required=stalled"); end
        step(); m_req_ready = 1'b1;
        wait_stall_drop(n, to);
        checks++; if (to || n != 1) begin errors++; $display("FAIL store_release_cycles actual=%0d required=1", n); end
        checks++; if (m_resp_valid !== 1'b1 || log_n - base != 1) begin
            errors++; $display("FAIL store_release_on_ack resp=%b writes=%0d required 1/1", m_resp_valid, log_n - base);
        end
        step(); cpu_write = 1'b0;
        wait_drain(to);
        checks++; if (to || log_n - base != 5) begin errors++; $display("FAIL store_write_count actual=%0d required=5", log_n - base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (base + i >= LOG_MAX || log_we[base+i] !== 1'b1 || log_addr[base+i] !== 32'h100 + 32'(4 * i)
                || log_wdata[base+i] !== 32'hA0 + 32'(i)) begin
                errors++; $display("FAIL store_write_%0d we=%b addr=%h data=%h required 1/%h/%h", i,
                    log_we[base+i], log_addr[base+i], log_wdata[base+i], 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            end
        end
        $display("test_store_burst done: writes=%0d", log_n - base);
    endtask

    task automatic test_store_load_same_addr();
        int n; bit to; int base;
        base = log_n;
        step(); cpu_write = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1234;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL fwd_store_stall actual=%b required=0", cpu_stall); end
        step(); cpu_write = 1'b0; cpu_read = 1'b1; cpu_addr = 32'h10;
        wait_stall_drop(n, to);
`ifdef DMEM_WBUF_FWD_EN
        checks++; if (to || n != 1) begin errors++; $display("FAIL fwd_stall_cycles actual=%0d required=1", n); end
`else
        checks++; if (to || n != 6) begin errors++; $display("FAIL nofwd_stall_cycles actual=%0d required=6", n); end
`endif
        checks++; if (cpu_rdata !== 32'h1234) begin errors++; $display("FAIL store_load_rdata actual=%h required=00001234", cpu_rdata); end
        step(); cpu_read = 1'b0;
        wait_drain(to);
`ifdef DMEM_WBUF_FWD_EN
        checks++; if (to || log_n - base != 1 || log_we[base] !== 1'b1) begin
            errors++; $display("FAIL fwd_no_read requests=%0d first_we=%b required 1/1", log_n - base, log_we[base]);
        end
`else
        checks++; if (to || log_n - base != 2 || log_we[base] !== 1'b1 || log_we[base+1] !== 1'b0
                      || log_addr[base+1] !== 32'h10) begin
            errors++; $display("FAIL nofwd_order requests=%0d we0=%b we1=%b addr1=%h required 2/1/0/00000010",
                log_n - base, log_we[base], log_we[base+1], log_addr[base+1]);
        end
        checks++; if (log_wbe[base+1] !== 1'b1) begin errors++; $display("FAIL nofwd_empty_before_read actual=%b required=1", log_wbe[base+1]); end
`endif
        $display("test_store_load_same_addr done: stall=%0d rdata=%h", n, cpu_rdata);
    endtask

    task automatic test_illegal_rw();
        int n; bit to; int base;
        base = log_n;
        step(); cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h55;
        $display("note: cpu_read and cpu_write driven together at 00000040 (illegal combination)");
        wait_stall_drop(n, to);
        checks++; if (to || n != 3) begin errors++; $display("FAIL illegal_stall_cycles actual=%0d required=3", n); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL illegal_rdata actual=%h required=deadbeef", cpu_rdata); end
        step(); cpu_read = 1'b0; cpu_write = 1'b0;
        wait_drain(to);
        checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL illegal_write_dropped wbuf_empty=%b required=1", wbuf_empty); end
        checks++; if (to || log_n - base != 1 || log_we[base] !== 1'b0) begin
            errors++; $display("FAIL illegal_requests count=%0d we=%b required 1/0", log_n - base, log_we[base]);
        end
        $display("test_illegal_rw done");
    endtask

    task automatic test_reset_in_rd_wait();
        int n; bit to;
        auto_resp = 1'b0;
        step(); m_req_ready = 1'b1; cpu_read = 1'b1; cpu_addr = 32'h80;
        step();
        step();
        rst = 1'b0; cpu_read = 1'b0; m_req_ready = 1'b0;
        @(negedge clk);
        checks++; if (m_req_valid !== 1'b0 || cpu_rdata !== '0) begin
            errors++; $display("FAIL rst_mid_clear req_valid=%b rdata=%h required 0/0", m_req_valid, cpu_rdata);
        end
        step(); rst = 1'b1; late_req++;
        step();
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0 || m_req_valid !== 1'b0) begin
            errors++; $display("FAIL late_resp_during stall=%b req_valid=%b required 0/0", cpu_stall, m_req_valid);
        end
        step();
        @(negedge clk);
        checks++; if (cpu_rdata !== '0) begin errors++; $display("FAIL late_resp_rdata actual=%h required=0", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0 || m_req_valid !== 1'b0 || wbuf_empty !== 1'b1) begin
            errors++; $display("FAIL late_resp_idle stall=%b req_valid=%b wbuf_empty=%b required 0/0/1",
                cpu_stall, m_req_valid, wbuf_empty);
        end
        auto_resp = 1'b1;
        step(); m_req_ready = 1'b1; cpu_read = 1'b1; cpu_addr = 32'h40;
        wait_stall_drop(n, to);
        checks++; if (to || n != 3 || cpu_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL post_reset_load stall=%0d rdata=%h required 3/deadbeef", n, cpu_rdata);
        end
        step(); cpu_read = 1'b0;
        $display("test_reset_in_rd_wait done");
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        cpu_read    = 1'b0;
        cpu_write   = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        m_req_ready = 1'b1;
        mem_model[32'h40] = 32'hDEAD_BEEF;
        test_reset();
        test_load();
        test_store_burst();
        test_store_load_same_addr();
        test_illegal_rw();
        test_reset_in_rd_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
